// File: rtl/pir_array_ctrl.sv
// pir_array_ctrl: multi-sensor PIR alarm controller with debounce, peak tracking and an event-log FIFO
module pir_array_ctrl #(
  parameter int NUM_SENSORS = 4,
  parameter int DATA_W = 7,
  parameter int DEBOUNCE = 3,
  parameter int BUZZ_CYCLES = 100,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int LOG_DEPTH = 8,
  localparam int IDX_W = NUM_SENSORS > 1 ? $clog2(NUM_SENSORS) : 1,
  localparam int CNT_W = $clog2(NUM_SENSORS + 1),
  localparam int LOG_W = NUM_SENSORS + IDX_W + DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic turn,
  input  logic stop_alarm,
  input  logic [DATA_W-1:0] threshold,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
  output logic [NUM_SENSORS-1:0] LED,
  output logic buzzer,
  output logic [CNT_W-1:0] trig_count,
  output logic [DATA_W-1:0] peak_value,
  output logic [IDX_W-1:0] peak_index,
  output logic [1:0] state,
  output logic log_valid,
  input  logic log_ready,
  output logic [LOG_W-1:0] log_data,
  output logic log_overflow
);
  typedef enum logic [1:0] {OFF, ARMED, ALARM, COOLDOWN} state_t;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int TMR_W = $clog2((BUZZ_CYCLES > HOLDOFF_CYCLES ? BUZZ_CYCLES : HOLDOFF_CYCLES) + 1);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  state_t st, st_nx;
  logic [DEB_W-1:0] deb [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] hit, qual;
  logic [TMR_W-1:0] tmr;
  logic [DATA_W-1:0] best_val;
  logic [IDX_W-1:0] best_idx;
  logic push, pop, wr_en;
  logic [LOG_W-1:0] mem [LOG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  always_comb begin
    hit = '0;
    qual = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      hit[i] = sensor_mask[i] && sensor_data[i*DATA_W +: DATA_W] >= threshold;
      qual[i] = deb[i] == DEB_W'(DEBOUNCE);
    end
  end
  // Scanning downward with >= leaves the lowest qualified index on ties.
  always_comb begin
    best_val = '0;
    best_idx = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--)
      if (qual[i] && sensor_data[i*DATA_W +: DATA_W] >= best_val) begin
        best_val = sensor_data[i*DATA_W +: DATA_W];
        best_idx = IDX_W'(i);
      end
  end
  always_comb begin
    st_nx = st;
    push = 1'b0;
    case (st)
      OFF: st_nx = turn ? ARMED : OFF;
      ARMED: st_nx = !turn ? OFF : |qual ? ALARM : ARMED;
      ALARM: begin
        st_nx = !turn ? OFF : (stop_alarm || tmr == TMR_W'(BUZZ_CYCLES - 1)) ? COOLDOWN : ALARM;
        push = st_nx == COOLDOWN;
      end
      COOLDOWN: st_nx = !turn ? OFF : tmr == TMR_W'(HOLDOFF_CYCLES - 1) ? ARMED : COOLDOWN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= OFF;
      tmr <= '0;
      LED <= '0;
      peak_value <= '0;
      peak_index <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) deb[i] <= '0;
    end else begin
      st <= st_nx;
      tmr <= st_nx != st ? '0 : tmr + 1'b1;
      for (int i = 0; i < NUM_SENSORS; i++)
        deb[i] <= (st == ARMED || st == ALARM) && hit[i] ? (qual[i] ? deb[i] : deb[i] + 1'b1) : '0;
      if (st_nx == OFF) begin
        LED <= '0;
        peak_value <= '0;
        peak_index <= '0;
      end else if (st_nx == COOLDOWN) begin
        LED <= '0;
      end else if (st == ARMED && st_nx == ALARM) begin
        LED <= qual;
        peak_value <= best_val;
        peak_index <= best_idx;
      end else if (st == ALARM) begin
        LED <= LED | qual;
        if (best_val > peak_value) begin
          peak_value <= best_val;
          peak_index <= best_idx;
        end
      end
    end
  end
  assign state = st;
  assign buzzer = st == ALARM;
  assign trig_count = CNT_W'($countones(LED));
  // count never exceeds LOG_DEPTH, so its MSB alone flags full.
  assign log_valid = count != '0;
  assign pop = log_valid && log_ready;
  assign wr_en = push && (!count[PTR_W] || pop);
  assign log_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {LED, peak_index, peak_value};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) log_overflow <= 1'b1;
      count <= count + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
    end
  end
endmodule

// File: doc/pir_array_ctrl.md
Name: pir_array_ctrl

Overview:
- Parametrised multi-sensor PIR alarm controller: N sensor channels with runtime threshold, per-channel enable mask and debounce.
- Runs an arm/alarm/cooldown state machine driving LEDs and a buzzer.
- Tracks peak reading and source channel per alarm episode.
- Pushes one record per completed episode into an on-chip event-log FIFO; the host drains it over a valid/ready handshake.

Parameters:
- NUM_SENSORS, 4, number of sensor channels (1..16)
- DATA_W, 7, width of each sensor reading and of threshold
- DEBOUNCE, 3, consecutive above-threshold cycles needed to qualify a channel (>=1)
- BUZZ_CYCLES, 100, alarm duration in cycles absent stop_alarm (>=2)
- HOLDOFF_CYCLES, 16, cooldown cycles with sensors ignored (>=1)
- LOG_DEPTH, 8, event FIFO entries (power of 2, >=2)
- Derived: IDX_W = clog2(NUM_SENSORS) (min 1); CNT_W = clog2(NUM_SENSORS+1); LOG_W = NUM_SENSORS+IDX_W+DATA_W

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- turn  in  1  system enable; 0 forces OFF
- stop_alarm  in  1  operator acknowledge; ends alarm early
- threshold  in  DATA_W  trigger level, sampled every cycle
- sensor_mask  in  NUM_SENSORS  1 = channel enabled
- sensor_data  in  NUM_SENSORS*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- LED  out  NUM_SENSORS  sticky per-channel triggered indicator during ALARM
- buzzer  out  1  high throughout ALARM
- trig_count  out  CNT_W  popcount of LED
- peak_value  out  DATA_W  highest qualified reading of current/last episode
- peak_index  out  IDX_W  channel of peak_value
- state  out  2  OFF=0, ARMED=1, ALARM=2, COOLDOWN=3
- log_valid  out  1  FIFO non-empty
- log_ready  in  1  host pop request
- log_data  out  LOG_W  head entry {led_set, peak_index, peak_value}, MSB first
- log_overflow  out  1  sticky: an entry was dropped

Behaviour:
- Reset: state=OFF; LED, buzzer, trig_count, peak_value, peak_index, log_overflow = 0; FIFO empty (log_valid=0); all debounce counters 0. Reset mid-episode discards the episode, no log entry.
- hit[i] = sensor_mask[i] && sensor_data[i] >= threshold (unsigned).
- Per channel, deb[i] increments while hit[i], saturating at DEBOUNCE; clears to 0 on any cycle with !hit[i].
- qual[i] = (deb[i]==DEBOUNCE), registered. A continuous hit from cycle t gives qual at t+DEBOUNCE.
- Debounce counters run in ARMED and ALARM only; held at 0 in OFF and COOLDOWN.
- Peak merge: among qual channels, the largest value wins; ties go to the lowest index. It replaces peak only if strictly greater than the current peak.
- OFF: LED, buzzer, peak cleared. turn=1 -> ARMED next cycle.
- ARMED:
  - turn=0 -> OFF.
  - Else any qual -> ALARM. On the transition cycle, LED<=qual, peak loaded from qual channels, alarm counter<=0.
- ALARM:
  - buzzer=1; LED |= qual each cycle; peak merge each cycle; counter increments.
  - Exit priority: turn=0 -> OFF (no log entry) > stop_alarm=1 -> COOLDOWN > counter==BUZZ_CYCLES-1 -> COOLDOWN.
  - ALARM lasts exactly BUZZ_CYCLES cycles when uninterrupted.
  - On a COOLDOWN exit, push {LED, peak_index, peak_value} as registered at the start of the exit cycle; the exit cycle's samples are excluded.
- COOLDOWN: LED=0, buzzer=0; peak_value/peak_index retained for display. After HOLDOFF_CYCLES cycles -> ARMED. turn=0 -> OFF at any time.
- FIFO:
  - Pop on log_valid && log_ready; log_data is head, valid same cycle (first-word fall-through).
  - Push when full without simultaneous pop -> entry dropped, log_overflow<=1.
  - Push and pop in the same cycle when full both succeed.
  - Pointers wrap modulo LOG_DEPTH.
  - Contents and log_overflow survive OFF; only rst clears them.
- trig_count is combinational from the LED register.
- Mask or threshold changes take effect on hit in the same cycle; deb clears next cycle if a hit is lost.

Test Plan:
- Reset, turn=1, all sensors 0, threshold=50 -> state OFF then ARMED; buzzer=0, log_valid=0 for 200 cycles.
- DEBOUNCE=3, ch2 held at 60 from cycle t, threshold=50 -> ALARM entered at t+4; buzzer=1 for exactly 100 cycles; COOLDOWN 16 cycles; then ARMED. One log entry {LED=0100, idx=2, peak=60}.
- Ch1 pulses at 70 for 2 cycles only -> no alarm. Ch1 and ch3 both held at 90 -> peak_index=1 (tie, lowest index); trig_count=2.
- Mid-alarm, ch0 rises to 120 then stop_alarm pulses at cycle 10 -> COOLDOWN next cycle. Entry peak=120, idx=0. sensor_mask[0]=0 with ch0=127 -> never triggers.
- 9 episodes with log_ready=0 -> log_overflow=1 and 8 entries retained. Then log_ready=1 -> 8 pops in order, and log_valid drops after the 8th.
- turn=0 mid-ALARM -> OFF next cycle; buzzer=0, LED=0, no entry pushed. rst mid-ALARM -> all outputs 0 and FIFO empty.
